sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 28 ++
 rtl/fifo_ptr.sv | 16 +
 rtl/sync_fifo_param.sv | 120 ++++++++++++
 tb/tb_sync_fifo_param.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and status type for the parametrised single-clock FIFO.
package sync_fifo_pkg;

    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int addr_w(input int depth);
        return clog2_min1(depth);
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int cnt_w(input int depth);
        return clog2_min1(depth) + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_status_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: ADDR_W address bits plus an MSB that toggles every pass.
module fifo_ptr #(
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (!reset_n)  ptr <= '0;
        else if (inc)  ptr <= ptr + PTR_W'(1);
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost thresholds, read-valid strobe
// and sticky overflow/underflow flags.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   clr_err,
    output logic [WIDTH-1:0]       data_out,
    output logic                   data_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 and at least 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $fatal(1, "sync_fifo_param: AFULL_THRESH out of range");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $fatal(1, "sync_fifo_param: AEMPTY_THRESH out of range");
    end
    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "sync_fifo_param: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [CNT_W-1:0]  wr_ptr, rd_ptr;
    fifo_status_t      st;
    logic              wr_en, rd_en;

    // Flags come straight from the registered count, so a same-cycle read
    // never frees room for a write and vice versa.
    assign st.empty        = (count == '0);
    assign st.full         = (count == CNT_W'(DEPTH));
    assign st.almost_empty = (count <= CNT_W'(AEMPTY_THRESH));
    assign st.almost_full  = (count >= CNT_W'(AFULL_THRESH));

    assign empty        = st.empty;
    assign full         = st.full;
    assign almost_empty = st.almost_empty;
    assign almost_full  = st.almost_full;

    assign wr_en = wr && !st.full;
    assign rd_en = rd && !st.empty;

    fifo_ptr #(.PTR_W(CNT_W)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (wr_en),
        .ptr     (wr_ptr)
    );

    fifo_ptr #(.PTR_W(CNT_W)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (rd_en),
        .ptr     (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset_n && wr_en) mem[wr_ptr[ADDR_W-1:0]] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_en;
            if (rd_en) data_out <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr && st.full)   overflow <= 1'b1;
            else if (clr_err)    overflow <= 1'b0;
            if (rd && st.empty)  underflow <= 1'b1;
            else if (clr_err)    underflow <= 1'b0;
        end
    end

    count_matches_ptrs: assert property (@(posedge clk) disable iff (!reset_n)
        count == CNT_W'(wr_ptr - rd_ptr));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: stimulus queues expected read data,
// a negedge monitor pops and compares whenever data_valid is high.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr, rd, clr_err;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic [4:0] count;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic       seen_aa  = 1'b0;

    sync_fifo_param #(
        .WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .rd           (rd),
        .data_in      (data_in),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Apply one cycle of inputs; returns #1 after the edge that consumed them.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
        wr = w; rd = r; data_in = d; clr_err = c;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_n && data_valid) begin
            if (data_out == 8'hAA) seen_aa <= 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: got data 0x%0h with nothing expected", data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    failures++;
                    $display("FAIL read_data: got 0x%0h expected 0x%0h", data_out, e);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data_in = '0;
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        reset_n = 1'b1;
        step(0, 0, 8'h00, 0);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);

        // Fill 0x00..0x0F, watching thresholds move
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'(i), 0);
            chk("fill_count", count, i + 1);
            chk("fill_aempty", almost_empty, (i + 1 <= 2) ? 1 : 0);
            chk("fill_afull", almost_full, (i + 1 >= 14) ? 1 : 0);
            chk("fill_full", full, (i + 1 == 16) ? 1 : 0);
            chk("fill_empty", empty, 0);
        end

        step(1, 0, 8'hAA, 0);
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_full", full, 1);

        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            step(0, 1, 8'h00, 0);
            chk("drain_count", count, 15 - i);
            chk("drain_valid", data_valid, 1);
        end
        step(0, 0, 8'h00, 0);
        chk("drain_empty", empty, 1);
        chk("drain_valid_low", data_valid, 0);
        chk("drain_dout_hold", data_out, 8'h0F);
        chk("ovf_sticky", overflow, 1);
        step(0, 0, 8'h00, 1);
        chk("ovf_clear", overflow, 0);

        // Preload 5, then 40 simultaneous wr+rd cycles across the pointer wrap
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i), 0);
        chk("pre_count", count, 5);
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(8'(8'h40 + i));
            step(1, 1, 8'(8'h45 + i), 0);
            chk("both_count", count, 5);
        end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'(8'h68 + i));
            step(0, 1, 8'h00, 0);
        end
        chk("wrap_empty", empty, 1);
        chk("wrap_udf_none", underflow, 0);

        step(0, 1, 8'h00, 0);
        chk("udf_flag", underflow, 1);
        chk("udf_valid", data_valid, 0);
        chk("udf_dout", data_out, 8'h6C);
        chk("udf_count", count, 0);
        step(0, 1, 8'h00, 1);
        chk("udf_set_wins", underflow, 1);
        step(0, 0, 8'h00, 1);
        chk("udf_clear", underflow, 0);

        // wr+rd on empty: only the write lands
        step(1, 1, 8'h77, 0);
        chk("empty_both_count", count, 1);
        chk("empty_both_udf", underflow, 1);
        chk("empty_both_valid", data_valid, 0);
        exp_q.push_back(8'h77);
        step(0, 1, 8'h00, 0);
        chk("empty_both_drain", count, 0);

        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h80 + i), 0);
        chk("pre_rst_count", count, 7);
        chk("pre_rst_udf", underflow, 1);
        reset_n = 1'b0;
        step(1, 0, 8'h99, 0);
        reset_n = 1'b1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_aempty", almost_empty, 1);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_udf", underflow, 0);
        chk("mid_rst_valid", data_valid, 0);
        chk("mid_rst_dout", data_out, 8'h00);

        step(0, 0, 8'h00, 0);
        chk("pending_reads", exp_q.size(), 0);
        chk("no_aa_seen", seen_aa, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
